// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state types and op-decode helpers shared by the iterative M-extension unit
package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_t;
    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction
    function automatic logic a_signed(input muldiv_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction
    function automatic logic b_signed(input muldiv_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: W-bit add or subtract with carry-out (carry-out low on subtract means borrow)
module muldiv_step #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_y,
    output logic         o_co
);
    assign {o_co, o_y} = {1'b0, i_a} + {1'b0, i_sub ? ~i_b : i_b} + {{W{1'b0}}, i_sub};
endmodule

// File: rtl/iter_muldiv.sv
// iter_muldiv: one-bit-per-cycle RV32M multiply/divide with valid/ready request and response
module iter_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);
    muldiv_state_t     r_state;
    muldiv_op_t        r_op;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_m, r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg_res, r_neg_rem;
    muldiv_op_t        w_op;
    logic              w_sa, w_sb, w_div0, w_ovf, w_co, w_div;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_spec, w_quo, w_rem, w_res;
    logic [XLEN:0]     w_step_a, w_step_b, w_y;
    logic [2*XLEN-1:0] w_acc_nx, w_prod;
    assign w_op    = muldiv_op_t'(req_op);
    assign w_sa    = a_signed(w_op) & req_a[XLEN-1];
    assign w_sb    = b_signed(w_op) & req_b[XLEN-1];
    assign w_abs_a = w_sa ? -req_a : req_a;
    assign w_abs_b = w_sb ? -req_b : req_b;
    assign w_div0  = is_div(w_op) & (req_b == '0);
    assign w_ovf   = is_div(w_op) & b_signed(w_op) & (req_a == {1'b1, {(XLEN-1){1'b0}}}) & (req_b == '1);
    assign w_spec  = w_div0 ? (w_op[1] ? req_a : '1) : (w_op[1] ? '0 : req_a);
    // Divide trial-subtracts the XLEN+1-bit shifted remainder; multiply adds into the high half.
    assign w_div    = is_div(r_op);
    assign w_step_a = w_div ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, r_acc[2*XLEN-1:XLEN]};
    assign w_step_b = {1'b0, r_m};
    muldiv_step #(.W(XLEN + 1)) u_step (
        .i_a  (w_step_a),
        .i_b  (w_step_b),
        .i_sub(w_div),
        .o_y  (w_y),
        .o_co (w_co)
    );
    assign w_acc_nx = w_div ? (w_co ? {w_y[XLEN-1:0], r_acc[XLEN-2:0], 1'b1} : {r_acc[2*XLEN-2:0], 1'b0})
                            : (r_acc[0] ? {w_y, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]});
    assign w_prod = r_neg_res ? -w_acc_nx : w_acc_nx;
    assign w_quo  = r_neg_res ? -w_acc_nx[XLEN-1:0] : w_acc_nx[XLEN-1:0];
    assign w_rem  = r_neg_rem ? -w_acc_nx[2*XLEN-1:XLEN] : w_acc_nx[2*XLEN-1:XLEN];
    assign w_res  = w_div ? (r_op[1] ? w_rem : w_quo)
                          : (r_op == OP_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_op      <= OP_MUL;
            r_acc     <= '0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_data    <= '0;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_op      <= w_op;
                    r_m       <= is_div(w_op) ? w_abs_b : w_abs_a;
                    r_acc     <= {{XLEN{1'b0}}, is_div(w_op) ? w_abs_a : w_abs_b};
                    r_cnt     <= CNT_W'(XLEN);
                    r_neg_res <= w_sa ^ w_sb;
                    r_neg_rem <= w_sa;
                    if (w_div0 | w_ovf) begin
                        r_data  <= w_spec;
                        r_state <= DONE;
                    end else begin
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_nx;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_data  <= w_res;
                        r_state <= DONE;
                    end
                end
                DONE: if (resp_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign resp_data  = r_data;
endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv: directed RV32M vectors with hand-computed results, handshake, flush and reset checks
module tb_iter_muldiv;
    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b, resp_data;
    int          total = 0;
    int          bad = 0;

    iter_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_op = op;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = 32'hFFFF_FFFF;
        req_b = 32'hFFFF_FFFF;
    endtask

    task automatic wait_done(input string tag, input int lat);
        int   n = 0;
        logic busy_all = 1'b1;
        while (!resp_valid && n < 200) begin
            busy_all &= busy;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_busy"}, {31'd0, busy_all & busy}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        issue(op, a, b);
        wait_done(tag, lat);
        chk({tag, "_data"}, resp_data, exp);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, "_idle"}, {29'd0, busy, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        flush = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        req_op = 3'd0;
        req_a = '0;
        req_b = '0;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32);
        run("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
        run("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
        run("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32);
        run("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32);
        run("divu",   3'b101, 32'd100,        32'd7,         32'd14,        32);
        run("remu",   3'b111, 32'd100,        32'd7,         32'd2,         32);
        run("divu0",  3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run("rem0",   3'b110, 32'd5,          32'd0,         32'd5,         0);
        run("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);

        issue(3'b101, 32'd100, 32'd7);
        wait_done("bp", 32);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_op = 3'b000;
            req_a = 32'd3;
            req_b = 32'd3;
            @(posedge clk);
            #1;
            chk("bp_data", resp_data, 32'd14);
            chk("bp_hold", {30'd0, req_ready, resp_valid}, 32'd1);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid = 1'b0;
        chk("bp_release", {29'd0, busy, resp_valid, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("bp_no_accept", {31'd0, busy}, 32'd0);

        @(negedge clk);
        req_valid = 1'b1;
        req_op = 3'b000;
        flush = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b0;
        chk("flush_idle_block", {31'd0, busy}, 32'd0);

        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {29'd0, busy, resp_valid, req_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= resp_valid;
        end
        chk("flush_no_resp", {31'd0, seen}, 32'd0);

        issue(3'b000, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_busy_valid", {30'd0, busy, resp_valid}, 32'd0);
        chk("arst_data", resp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("mul34", 3'b000, 32'd3, 32'd4, 32'd12, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
